// File: rtl/aurora_hls_monitor_readout_if.sv
// AXI4-Lite slave bundle for the Aurora monitor readout block.
// The master modport is the kernel control interconnect side; the slave modport is the register block.
interface aurora_hls_monitor_readout_if #(
    parameter int ADDR_WIDTH = 5
);
    // Write address channel
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;

    // Write data channel
    logic                  wvalid;
    logic                  wready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;

    // Write response channel
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;

    // Read address channel
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;

    // Read data channel
    logic                  rvalid;
    logic                  rready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/aurora_hls_monitor_readout.sv
// Aurora link monitor readout: AXI4-Lite register responder exposing the monitor
// error counters (snapshot-coherent on a read of the first counter), the live core
// status word, and a control register that launches a fixed-length counter clear pulse.
module aurora_hls_monitor_readout #(
    parameter int ADDR_WIDTH   = 5,
    parameter int CLEAR_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] core_status_not_ok_count,
    input  logic [31:0] fifo_rx_overflow_count,
    input  logic [31:0] fifo_tx_overflow_count,
    input  logic [12:0] aurora_status,
    output logic        clear_req,
    aurora_hls_monitor_readout_if.slave s_axi
);

    // Word addresses (addr[4:2]) of the register map.
    localparam logic [2:0] A_CORE   = 3'd0;
    localparam logic [2:0] A_RX     = 3'd1;
    localparam logic [2:0] A_TX     = 3'd2;
    localparam logic [2:0] A_STATUS = 3'd3;
    localparam logic [2:0] A_CTRL   = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Status word that means the link is fully up (lanes, channel, PLL all good).
    localparam logic [12:0] STATUS_ALL_OK = 13'h11ff;

    localparam logic [7:0] CLR_LOAD = 8'(CLEAR_CYCLES);

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    // Read channel state and registered response.
    rd_state_t   r_rd_state;
    rd_state_t   w_rd_next;
    logic [31:0] r_rdata;
    logic [31:0] w_rdata_next;
    logic [1:0]  r_rresp;
    logic [1:0]  w_rresp_next;

    // Write channel state and registered response.
    wr_state_t   r_wr_state;
    wr_state_t   w_wr_next;
    logic [1:0]  r_bresp;
    logic [1:0]  w_bresp_next;

    // Ready outputs stay low while rst is asserted and for the first edge after release.
    logic        r_live;

    // Snapshot of the rx/tx counters taken together with the core counter read.
    logic [31:0] r_shadow_rx;
    logic [31:0] r_shadow_tx;

    // Clear pulse generator.
    logic [7:0]  r_clr_cnt;
    logic        r_clr_start;

    logic [2:0]  w_rd_word;
    logic [2:0]  w_wr_word;
    logic        w_ar_hs;
    logic        w_wr_accept;
    logic        w_capture;
    logic        w_clr_write;
    logic [31:0] w_status_word;
    logic        w_unused;

    assign w_rd_word = s_axi.araddr[4:2];
    assign w_wr_word = s_axi.awaddr[4:2];

    // Read channel handshake signals.
    assign s_axi.arready = r_live && (r_rd_state == R_IDLE);
    assign s_axi.rvalid  = (r_rd_state == R_DATA);
    assign s_axi.rdata   = r_rdata;
    assign s_axi.rresp   = r_rresp;
    assign w_ar_hs       = s_axi.arvalid && s_axi.arready;

    // Address and data are taken only together; a lone awvalid or wvalid sees no ready.
    assign w_wr_accept   = r_live && (r_wr_state == W_IDLE) && s_axi.awvalid && s_axi.wvalid;
    assign s_axi.awready = w_wr_accept;
    assign s_axi.wready  = w_wr_accept;
    assign s_axi.bvalid  = (r_wr_state == W_RESP);
    assign s_axi.bresp   = r_bresp;

    // Reading the core counter freezes rx/tx alongside it.
    assign w_capture   = w_ar_hs && (w_rd_word == A_CORE);

    // Only byte lane 0, bit 0 of the control register does anything.
    assign w_clr_write = w_wr_accept && (w_wr_word == A_CTRL) && s_axi.wdata[0] && s_axi.wstrb[0];

    // Clear stays high exactly while the counter is nonzero, so an async reset drops it at once.
    assign clear_req   = (r_clr_cnt != 8'd0);

    assign w_status_word = {(aurora_status == STATUS_ALL_OK), 18'b0, aurora_status};

    // Address/data bits outside the decoded fields are deliberately ignored.
    assign w_unused = ^{s_axi.araddr[1:0], s_axi.awaddr[1:0], s_axi.wdata[31:1], s_axi.wstrb[3:1]};

    // Ready enable: held off through reset, raised on the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_live <= 1'b0;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
            r_live <= 1'b1;
        end
    end

    // Read channel next state and response data.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the case can infer a latch.
        w_rd_next    = r_rd_state;
        w_rdata_next = r_rdata;
        w_rresp_next = r_rresp;
        case (r_rd_state)
            R_IDLE: begin
                if (w_ar_hs) begin
                    w_rd_next    = R_DATA;
                    w_rresp_next = RESP_OKAY;
                    case (w_rd_word)
                        A_CORE:   w_rdata_next = core_status_not_ok_count;
                        A_RX:     w_rdata_next = r_shadow_rx;
                        A_TX:     w_rdata_next = r_shadow_tx;
                        A_STATUS: w_rdata_next = w_status_word;
                        A_CTRL:   w_rdata_next = {31'b0, clear_req};
                        default: begin
                            w_rdata_next = 32'b0;
                            w_rresp_next = RESP_SLVERR;
                        end
                    endcase
                end
            end
            R_DATA: begin
                if (s_axi.rready) begin
                    w_rd_next = R_IDLE;
                end
            end
        endcase
    end

    // Read channel state and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_state <= R_IDLE;
            r_rdata    <= 32'b0;
            r_rresp    <= RESP_OKAY;
        end else begin
            r_rd_state <= w_rd_next;
            r_rdata    <= w_rdata_next;
            r_rresp    <= w_rresp_next;
        end
    end

    // Write channel next state and response code.
    always_comb begin
        w_wr_next    = r_wr_state;
        w_bresp_next = r_bresp;
        case (r_wr_state)
            W_IDLE: begin
                if (w_wr_accept) begin
                    w_wr_next    = W_RESP;
                    w_bresp_next = (w_wr_word == A_CTRL) ? RESP_OKAY : RESP_SLVERR;
                end
            end
            W_RESP: begin
                if (s_axi.bready) begin
                    w_wr_next = W_IDLE;
                end
            end
        endcase
    end

    // Write channel state and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_state <= W_IDLE;
            r_bresp    <= RESP_OKAY;
        end else begin
            r_wr_state <= w_wr_next;
            r_bresp    <= w_bresp_next;
        end
    end

    // Clear pulse: load on an accepted clear write (reload extends it), count down to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clr_cnt   <= 8'd0;
            r_clr_start <= 1'b0;
        end else begin
            // Flag the first cycle of a fresh pulse; a reload mid-pulse is not a new start.
            r_clr_start <= w_clr_write && (r_clr_cnt == 8'd0);
            if (w_clr_write) begin
                r_clr_cnt <= CLR_LOAD;
            end else if (r_clr_cnt != 8'd0) begin
                r_clr_cnt <= r_clr_cnt - 8'd1;
            end
        end
    end

    // Shadow snapshot: a core-counter read captures; otherwise the first clear cycle zeroes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the shadows are plain flops, not a RAM, so they can and do take the async reset.
            r_shadow_rx <= 32'b0;
            r_shadow_tx <= 32'b0;
        end else if (w_capture) begin
            r_shadow_rx <= fifo_rx_overflow_count;
            r_shadow_tx <= fifo_tx_overflow_count;
        end else if (r_clr_start) begin
            r_shadow_rx <= 32'b0;
            r_shadow_tx <= 32'b0;
        end
    end

endmodule

// File: tb/tb_aurora_hls_monitor_readout.sv
// Self-checking bench for aurora_hls_monitor_readout: a cycle-stamped reference model
// pushes expected read/write responses into queues; decoupled monitors pop and compare.
module tb_aurora_hls_monitor_readout;

    localparam int AW  = 5;
    localparam int CLR = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] core_cnt = 32'd0;
    logic [31:0] rx_cnt   = 32'd0;
    logic [31:0] tx_cnt   = 32'd0;
    logic [12:0] status   = 13'd0;
    logic        clear_req;

    aurora_hls_monitor_readout_if #(.ADDR_WIDTH(AW)) s_axi ();

    aurora_hls_monitor_readout #(
        .ADDR_WIDTH  (AW),
        .CLEAR_CYCLES(CLR)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .core_status_not_ok_count(core_cnt),
        .fifo_rx_overflow_count  (rx_cnt),
        .fifo_tx_overflow_count  (tx_cnt),
        .aurora_status           (status),
        .clear_req               (clear_req),
        .s_axi                   (s_axi)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        int          cyc;
    } rexp_t;

    typedef struct {
        logic [1:0] resp;
        int         cyc;
    } bexp_t;

    rexp_t rq[$];
    bexp_t bq[$];

    // cyc numbers clock cycles since reset; clear_req is expected high in cycles cyc <= clr_last.
    int          cyc      = 1;
    int          clr_last = 0;
    int          zero_cyc = -1;
    logic [31:0] m_rx     = 32'd0;
    logic [31:0] m_tx     = 32'd0;
    bit          m_clr_now;
    int          m_word;
    rexp_t       m_r;
    bexp_t       m_b;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc      = 1;
            clr_last = 0;
            zero_cyc = -1;
            m_rx     = 32'd0;
            m_tx     = 32'd0;
            rq.delete();
            bq.delete();
        end else begin
            m_clr_now = (cyc <= clr_last);
            if (s_axi.arvalid && s_axi.arready) begin
                m_word = int'(s_axi.araddr) / 4;
                m_r.resp = 2'b00;
                m_r.cyc  = cyc;
                case (m_word)
                    0: m_r.data = core_cnt;
                    1: m_r.data = m_rx;
                    2: m_r.data = m_tx;
                    3: m_r.data = 32'(status) + ((status == 13'h11ff) ? 32'h8000_0000 : 32'd0);
                    4: m_r.data = m_clr_now ? 32'd1 : 32'd0;
                    default: begin
                        m_r.data = 32'd0;
                        m_r.resp = 2'b10;
                    end
                endcase
                rq.push_back(m_r);
                if (m_word == 0) begin
                    m_rx = rx_cnt;
                    m_tx = tx_cnt;
                end else if (cyc == zero_cyc) begin
                    m_rx = 32'd0;
                    m_tx = 32'd0;
                end
            end else if (cyc == zero_cyc) begin
                m_rx = 32'd0;
                m_tx = 32'd0;
            end
            if (s_axi.awvalid && s_axi.wvalid && s_axi.awready && s_axi.wready) begin
                m_b.cyc  = cyc;
                m_b.resp = (int'(s_axi.awaddr) / 4 == 4) ? 2'b00 : 2'b10;
                bq.push_back(m_b);
                if (int'(s_axi.awaddr) / 4 == 4 && s_axi.wdata[0] && s_axi.wstrb[0]) begin
                    if (!m_clr_now) zero_cyc = cyc + 1;
                    clr_last = cyc + CLR;
                end
            end
            cyc++;
        end
    end

    // ---------------- monitors ----------------
    bit          r_busy = 1'b0;
    bit          b_busy = 1'b0;
    logic [31:0] r_held;
    logic [1:0]  b_held;
    rexp_t       r_cur;
    bexp_t       b_cur;

    always @(negedge clk) begin
        if (rst) begin
            r_busy = 1'b0;
            b_busy = 1'b0;
        end else begin
            check(clear_req == (cyc <= clr_last), "clear_req", 64'(clear_req), 64'(cyc <= clr_last));
            if (s_axi.rvalid) begin
                check(!s_axi.arready, "arready_low_in_rdata", 64'(s_axi.arready), 64'd0);
                if (!r_busy) begin
                    r_busy = 1'b1;
                    r_held = s_axi.rdata;
                    check(rq.size() != 0, "rvalid_expected", 64'(rq.size()), 64'd1);
                    if (rq.size() != 0) begin
                        r_cur = rq.pop_front();
                        check(s_axi.rdata == r_cur.data, "rdata", 64'(s_axi.rdata), 64'(r_cur.data));
                        check(s_axi.rresp == r_cur.resp, "rresp", 64'(s_axi.rresp), 64'(r_cur.resp));
                        check(cyc == r_cur.cyc + 1, "read_latency", 64'(cyc - r_cur.cyc), 64'd1);
                    end
                end else begin
                    check(s_axi.rdata == r_held, "rdata_stable", 64'(s_axi.rdata), 64'(r_held));
                end
                if (s_axi.rready) r_busy = 1'b0;
            end
            if (s_axi.bvalid) begin
                if (!b_busy) begin
                    b_busy = 1'b1;
                    b_held = s_axi.bresp;
                    check(bq.size() != 0, "bvalid_expected", 64'(bq.size()), 64'd1);
                    if (bq.size() != 0) begin
                        b_cur = bq.pop_front();
                        check(s_axi.bresp == b_cur.resp, "bresp", 64'(s_axi.bresp), 64'(b_cur.resp));
                        check(cyc == b_cur.cyc + 1, "write_latency", 64'(cyc - b_cur.cyc), 64'd1);
                    end
                end else begin
                    check(s_axi.bresp == b_held, "bresp_stable", 64'(s_axi.bresp), 64'(b_held));
                end
                if (s_axi.bready) b_busy = 1'b0;
            end
        end
    end

    // ---------------- drivers (inputs change 1 ns after the rising edge) ----------------
    task automatic rd(input logic [AW-1:0] a);
        bit got = 1'b0;
        s_axi.araddr  = a;
        s_axi.arvalid = 1'b1;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            got = s_axi.arready;
            @(posedge clk);
            #1;
        end
        s_axi.arvalid = 1'b0;
        check(got, "ar_handshake", 64'(got), 64'd1);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s, input int lead);
        bit got = 1'b0;
        s_axi.awaddr  = a;
        s_axi.wdata   = d;
        s_axi.wstrb   = s;
        s_axi.awvalid = 1'b1;
        for (int i = 0; i < lead; i++) begin
            @(negedge clk);
            check(!s_axi.awready && !s_axi.wready, "lone_awvalid_no_ready",
                  64'({s_axi.awready, s_axi.wready}), 64'd0);
            @(posedge clk);
            #1;
        end
        s_axi.wvalid = 1'b1;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            got = s_axi.awready && s_axi.wready;
            @(posedge clk);
            #1;
        end
        s_axi.awvalid = 1'b0;
        s_axi.wvalid  = 1'b0;
        check(got, "aw_w_handshake", 64'(got), 64'd1);
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 50 && !idle; i++) begin
            @(posedge clk);
            #2;
            idle = (rq.size() == 0) && (bq.size() == 0) && !r_busy && !b_busy;
        end
        check(idle, "responses_drained", 64'(idle), 64'd1);
    endtask

    task automatic count_clear(input int n, output int hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (clear_req) hi++;
        end
    endtask

    // ---------------- stimulus ----------------
    int pulse_len;
    int op;
    logic [AW-1:0] ra;
    logic [AW-1:0] wa;
    logic [31:0]   wd;
    logic [3:0]    ws;

    initial begin
        s_axi.awvalid = 1'b0;
        s_axi.awaddr  = '0;
        s_axi.wvalid  = 1'b0;
        s_axi.wdata   = '0;
        s_axi.wstrb   = '0;
        s_axi.bready  = 1'b1;
        s_axi.arvalid = 1'b0;
        s_axi.araddr  = '0;
        s_axi.rready  = 1'b1;

        #1;
        check(!s_axi.arready && !s_axi.awready && !s_axi.rvalid && !s_axi.bvalid && !clear_req,
              "reset_outputs_low",
              64'({s_axi.arready, s_axi.awready, s_axi.rvalid, s_axi.bvalid, clear_req}), 64'd0);
        check(s_axi.rdata == 32'd0 && s_axi.rresp == 2'b00 && s_axi.bresp == 2'b00,
              "reset_data_zero", 64'({s_axi.rdata, s_axi.rresp, s_axi.bresp}), 64'd0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: coherent snapshot
        core_cnt = 32'd5; rx_cnt = 32'd7; tx_cnt = 32'd9;
        rd(5'h00);
        wait_idle();
        core_cnt = 32'd6; rx_cnt = 32'd8; tx_cnt = 32'd10;
        rd(5'h04);
        rd(5'h08);
        wait_idle();

        // 2: status word
        status = 13'h11ff;
        rd(5'h0c);
        status = 13'h01ff;
        rd(5'h0c);
        wait_idle();

        // 3: clear pulse, then extended clear pulse
        fork
            wr(5'h10, 32'd1, 4'h1, 0);
            count_clear(14, pulse_len);
        join
        check(pulse_len == CLR, "clear_pulse_len", 64'(pulse_len), 64'(CLR));
        rd(5'h04);
        rd(5'h08);
        wait_idle();
        fork
            begin
                wr(5'h10, 32'd1, 4'h1, 0);
                wr(5'h10, 32'd3, 4'h1, 0);
            end
            count_clear(16, pulse_len);
        join
        check(pulse_len == CLR + 2, "clear_pulse_extended", 64'(pulse_len), 64'(CLR + 2));
        wait_idle();

        // 4: unmapped read, non-control write
        rd(5'h14);
        wr(5'h04, 32'd1, 4'h1, 0);
        wait_idle();
        wr(5'h10, 32'd1, 4'h0, 0);
        wait_idle();

        // 5: read backpressure, then lone awvalid
        s_axi.rready = 1'b0;
        core_cnt = 32'hdead_beef;
        rd(5'h00);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check(s_axi.rvalid && !s_axi.arready, "stall_rvalid_held",
                  64'({s_axi.rvalid, s_axi.arready}), 64'd2);
        end
        @(posedge clk);
        #1 s_axi.rready = 1'b1;
        wait_idle();
        wr(5'h04, 32'd1, 4'h1, 3);
        wait_idle();

        // randomized traffic, including reads and writes in the same cycle
        for (int n = 0; n < 80; n++) begin
            core_cnt = $urandom;
            rx_cnt   = $urandom;
            tx_cnt   = $urandom;
            status   = ($urandom_range(0, 3) == 0) ? 13'h11ff : 13'($urandom);
            ra = AW'($urandom_range(0, 7) * 4);
            wa = ($urandom_range(0, 1) == 0) ? 5'h10 : AW'($urandom_range(0, 7) * 4);
            wd = $urandom | 32'($urandom_range(0, 3) != 0);
            ws = 4'($urandom_range(0, 15));
            op = $urandom_range(0, 2);
            case (op)
                0: rd(ra);
                1: wr(wa, wd, ws, 0);
                default: fork
                    rd(ra);
                    wr(wa, wd, ws, 0);
                join
            endcase
            if ($urandom_range(0, 3) == 0) wait_idle();
        end
        wait_idle();

        // 6: reset in the middle of a clear pulse with responses pending
        s_axi.bready = 1'b0;
        s_axi.rready = 1'b0;
        wr(5'h10, 32'd1, 4'h1, 0);
        rd(5'h00);
        @(negedge clk);
        check(clear_req && s_axi.rvalid && s_axi.bvalid, "pending_before_rst",
              64'({clear_req, s_axi.rvalid, s_axi.bvalid}), 64'd7);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check(!clear_req && !s_axi.rvalid && !s_axi.bvalid, "rst_drops_all",
              64'({clear_req, s_axi.rvalid, s_axi.bvalid}), 64'd0);
        s_axi.rready = 1'b1;
        s_axi.bready = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        core_cnt = 32'd42; rx_cnt = 32'd43; tx_cnt = 32'd44;
        @(posedge clk);
        #1;
        rd(5'h00);
        rd(5'h04);
        rd(5'h08);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
